syn_av_mm_cap_fifo: RTL and testbench
=====================================

// Module: syn_av_mm_cap_fifo
// PURPOSE
//  Avalon-MM slave that sits directly downstream of the Avalon-MM master interface.
//  It consumes av_read/av_write/av_addr/av_write_data and returns av_read_data/av_rd_data_valid.
//  It captures a streaming word source into a FIFO and exposes three things through a small register map:
//  capture control, FIFO status, and a pop-on-read data port.
// PARAMETERS
//  ADDR_W      12  Avalon address width; only av_addr[1:0] is decoded, upper bits must be 0 for a hit
//  DATA_W      32  Avalon data width and capture word width (>=20)
//  FIFO_DEPTH  16  capture FIFO depth in words; power of 2, >=4
// PORTS
//  av_clk            in   1          single clock for all logic
//  av_rst            in   1          asynchronous reset, active-low
//  av_read           in   1          1 -> read transaction this cycle
//  av_write          in   1          1 -> write transaction this cycle
//  av_addr           in   ADDR_W     word address
//  av_write_data     in   DATA_W     write data
//  av_read_data      out  DATA_W     read data, valid when av_rd_data_valid=1
//  av_rd_data_valid  out  1          1 -> av_read_data valid
//  cap_data          in   DATA_W     capture stream data
//  cap_valid         in   1          1 -> cap_data presented this cycle (no backpressure)
//  fifo_nempty       out  1          level: FIFO fill count != 0 (interrupt source)
// BEHAVIOUR
//  Register map (word addresses):
//   0 CTRL    RW  [0] cap_en; [1] fifo_clr, write-1 self-clearing, reads 0
//   1 STATUS  RO/W1C  [PTR_W:0] fill count; [16] empty; [17] full; [18] ovf sticky, W1C
//   2 DATA    RO  read pops the FIFO head word
//   3/other   reads return 0; writes are ignored
//  Reset (av_rst=0): av_read_data=0, av_rd_data_valid=0, cap_en=0, ovf=0, pointers=0, count=0, fifo_nempty=0.
//  Read latency is fixed at 1:
//   - av_read in cycle N -> av_rd_data_valid=1 and av_read_data registered in N+1.
//   - av_rd_data_valid=0 in every other cycle; av_read_data holds its last value.
//  Back-to-back reads: one result per cycle, in order.
//  av_read and av_write in the same cycle: write is performed, read is ignored (no valid, no pop).
//  Push: cap_valid & cap_en & !full -> write mem[wr_ptr], wr_ptr++.
//  Overflow: cap_valid & cap_en & full -> word dropped, ovf set to 1.
//  cap_valid while cap_en=0: ignored, no ovf.
//  Pop: read of DATA with !empty -> av_read_data=mem[rd_ptr], rd_ptr++.
//  Underflow: read of DATA while empty -> av_read_data=0, no pointer change, valid still returned.
//  Push and pop in the same cycle: both happen and count is unchanged.
//   - full/empty are evaluated on the count registered before the cycle.
//   - A push while full is dropped even if a pop occurs in the same cycle.
//  Pointers are PTR_W=log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is PTR_W+1 bits, 0..FIFO_DEPTH.
//  fifo_clr=1 write: pointers and count go to 0 on the next edge.
//   - Clear wins over a same-cycle push or pop; that push is dropped, that pop returns 0.
//   - ovf is unaffected.
//  STATUS write: bit18=1 clears ovf; if overflow occurs in the same cycle, set wins. Other bits are ignored.
//  STATUS/DATA reads sample state before that cycle's push/pop/clear.
//  Reset asserted mid-transaction: all state clears immediately; a pending rd_data_valid is cancelled.
// TESTING
//  T1 reset: assert av_rst=0 mid-stream -> all outputs 0 immediately; STATUS reads 0x0001_0000 after release.
//  T2 CTRL=1; push 3 words A,B,C; read DATA x3 back-to-back -> valid on 3 consecutive cycles, A,B,C; then STATUS=0x0001_0000.
//  T3 cap_en=1, 18 pushes with DEPTH=16 -> STATUS fill=16, full=1, ovf=1; reads return first 16 words; write STATUS 0x4_0000 -> ovf=0.
//  T4 wrap: push 10/pop 10 twice, then push 16 -> data order intact across pointer wrap; fill=16 exactly.
//  T5 simultaneous: FIFO half full, push and DATA read in the same cycle -> count unchanged, head word returned;
//     full + push + pop -> push dropped, ovf=1.
//  T6 edge cases: DATA read when empty -> valid with data 0;
//     CTRL write 0x3 with concurrent cap_valid -> FIFO empty, word dropped, cap_en=1;
//     av_read+av_write same cycle -> no valid; read of addr 3 -> 0.

Source files
------------

// File: rtl/syn_av_mm_cap_fifo_if.sv
// Avalon-MM bus bundle between a master and the capture FIFO slave.
//   av_read / av_write     : transaction strobes from the master
//   av_addr / av_write_data: word address and write data from the master
//   av_read_data           : read data returned by the slave
//   av_rd_data_valid       : one-cycle strobe qualifying av_read_data
interface syn_av_mm_cap_fifo_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();
  logic              av_read;
  logic              av_write;
  logic [ADDR_W-1:0] av_addr;
  logic [DATA_W-1:0] av_write_data;
  logic [DATA_W-1:0] av_read_data;
  logic              av_rd_data_valid;

  modport master (
    output av_read, av_write, av_addr, av_write_data,
    input  av_read_data, av_rd_data_valid
  );

  modport slave (
    input  av_read, av_write, av_addr, av_write_data,
    output av_read_data, av_rd_data_valid
  );
endinterface

// File: rtl/syn_av_mm_cap_fifo.sv
// Avalon-MM slave that captures a streaming word source into a FIFO.
// Register map (word address, upper address bits must be zero):
//   0 CTRL   [0] cap_en, [1] fifo_clr (write-1 pulse, reads 0)
//   1 STATUS [PTR_W:0] fill count, [16] empty, [17] full, [18] ovf (W1C)
//   2 DATA   read pops the FIFO head (0 when empty)
//   3        reads 0, writes ignored
// Ports:
//   av_clk, av_rst       : clock, asynchronous active-low reset
//   av                   : Avalon-MM slave bus, fixed read latency of 1
//   cap_data, cap_valid  : capture stream, no backpressure
//   fifo_nempty          : level, FIFO fill count != 0
module syn_av_mm_cap_fifo #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 av_clk,
  input  logic                 av_rst,
  syn_av_mm_cap_fifo_if.slave  av,
  input  logic [DATA_W-1:0]    cap_data,
  input  logic                 cap_valid,
  output logic                 fifo_nempty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cap_en_q, cap_en_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  logic hit, sel_ctrl, sel_status, sel_data;
  logic wr, rd, empty, full, clr, cap, push, pop, ovf_set;
  logic [DATA_W-1:0] status_w;
  logic unused_wdata;

  assign hit        = (av.av_addr[ADDR_W-1:2] == '0);
  assign sel_ctrl   = hit && (av.av_addr[1:0] == 2'd0);
  assign sel_status = hit && (av.av_addr[1:0] == 2'd1);
  assign sel_data   = hit && (av.av_addr[1:0] == 2'd2);

  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign wr = av.av_write;
  assign rd = av.av_read && !av.av_write;

  // Full/empty come from the count registered before this cycle.
  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  assign clr     = wr && sel_ctrl && av.av_write_data[1];
  assign cap     = cap_valid && cap_en_q;
  assign push    = cap && !full && !clr;
  assign ovf_set = cap && full;
  // clr needs a write and pop needs a non-write read, so they never coincide.
  assign pop     = rd && sel_data && !empty;

  assign unused_wdata = ^av.av_write_data;

  always_comb begin
    status_w            = '0;
    status_w[PTR_W:0]   = count_q;
    status_w[16]        = empty;
    status_w[17]        = full;
    status_w[18]        = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    if (sel_ctrl) begin
      rdata_d[0] = cap_en_q;
    end else if (sel_status) begin
      rdata_d = status_w;
    end else if (sel_data && !empty) begin
      rdata_d = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    cap_en_d = cap_en_q;
    if (wr && sel_ctrl) cap_en_d = av.av_write_data[0];
    // Overflow in the same cycle as a W1C write keeps the flag set.
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (wr && sel_status && av.av_write_data[18]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge av_clk or negedge av_rst) begin
    if (!av_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cap_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cap_en_q <= cap_en_d;
      ovf_q    <= ovf_d;
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge av_clk) begin
    if (push) mem_q[wr_ptr_q] <= cap_data;
  end

  assign av.av_read_data     = rdata_q;
  assign av.av_rd_data_valid = rvalid_q;
  assign fifo_nempty         = (count_q != '0);

endmodule

// File: tb/tb_syn_av_mm_cap_fifo.sv
module tb_syn_av_mm_cap_fifo;
  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cap_data = '0;
  logic        cap_valid = 1'b0;
  logic        fifo_nempty;

  syn_av_mm_cap_fifo_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  syn_av_mm_cap_fifo #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(Depth)) dut (
    .av_clk      (clk),
    .av_rst      (rst_n),
    .av          (bus),
    .cap_data    (cap_data),
    .cap_valid   (cap_valid),
    .fifo_nempty (fifo_nempty)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue plus the two control flags.
  logic [31:0] mq[$];
  bit          cap_en_m = 1'b0;
  bit          ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.av_read = 1'b0;
    bus.av_write = 1'b0;
    bus.av_addr = '0;
    bus.av_write_data = '0;
    cap_valid = 1'b0;
  endtask

  // Predict the effect of the inputs currently driven, clock once, then check.
  task automatic tick(input string tag);
    logic [31:0] wd = bus.av_write_data;
    logic [11:0] a = bus.av_addr;
    bit wr = bus.av_write;
    bit rd = bus.av_read && !bus.av_write;
    int ridx = (a[11:2] == 10'd0) ? int'(a[1:0]) : 3;
    int sz = mq.size();
    bit full = (sz == Depth);
    bit empty = (sz == 0);
    bit clr = wr && ridx == 0 && wd[1];
    bit cap = cap_valid && cap_en_m;
    bit pop = rd && ridx == 2 && !empty;
    bit push = cap && !full && !clr;
    logic [31:0] exp;
    case (ridx)
      0:       exp = {31'd0, cap_en_m};
      1:       exp = (32'(ovf_m) << 18) | (32'(full) << 17) | (32'(empty) << 16) | 32'(sz);
      2:       exp = empty ? 32'd0 : mq[0];
      default: exp = 32'd0;
    endcase
    if (clr) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(cap_data);
    end
    if (wr && ridx == 0) cap_en_m = wd[0];
    if (cap && full) ovf_m = 1'b1;
    else if (wr && ridx == 1 && wd[18]) ovf_m = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(bus.av_rd_data_valid), 32'(rd));
    if (rd) chk({tag, "_rdata"}, bus.av_read_data, exp);
    chk({tag, "_nempty"}, 32'(fifo_nempty), 32'(mq.size() != 0));
  endtask

  task automatic rd_reg(input logic [11:0] a, input string tag);
    bus.av_read = 1'b1;
    bus.av_addr = a;
    tick(tag);
    bus.av_read = 1'b0;
  endtask

  task automatic wr_reg(input logic [11:0] a, input logic [31:0] d, input string tag);
    bus.av_write = 1'b1;
    bus.av_addr = a;
    bus.av_write_data = d;
    tick(tag);
    bus.av_write = 1'b0;
  endtask

  task automatic push_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cap_valid = 1'b1;
      cap_data = $urandom;
      tick(tag);
    end
    cap_valid = 1'b0;
  endtask

  task automatic pop_n(input int n, input string tag);
    for (int i = 0; i < n; i++) rd_reg(12'd2, tag);
  endtask

  initial begin
    idle();
    // T1: reset state and first status read.
    #1;
    chk("rst_valid", 32'(bus.av_rd_data_valid), 32'd0);
    chk("rst_rdata", bus.av_read_data, 32'd0);
    chk("rst_nempty", 32'(fifo_nempty), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_reg(12'd1, "t1_status");
    chk("t1_status_const", bus.av_read_data, 32'h0001_0000);

    // T2: three pushes read back-to-back.
    wr_reg(12'd0, 32'd1, "t2_ctrl");
    push_n(3, "t2_push");
    bus.av_read = 1'b1;
    bus.av_addr = 12'd2;
    for (int i = 0; i < 3; i++) tick("t2_b2b");
    bus.av_read = 1'b0;
    tick("t2_gap");
    rd_reg(12'd1, "t2_status");
    chk("t2_status_const", bus.av_read_data, 32'h0001_0000);

    // T3: overflow, drain, W1C.
    push_n(18, "t3_push");
    rd_reg(12'd1, "t3_status");
    chk("t3_status_const", bus.av_read_data, 32'h0006_0010);
    pop_n(16, "t3_pop");
    wr_reg(12'd1, 32'h0004_0000, "t3_w1c");
    rd_reg(12'd1, "t3_status2");
    chk("t3_status2_const", bus.av_read_data, 32'h0001_0000);

    // T4: pointer wrap.
    for (int r = 0; r < 2; r++) begin
      push_n(10, "t4_push");
      pop_n(10, "t4_pop");
    end
    push_n(16, "t4_fill");
    rd_reg(12'd1, "t4_status");
    chk("t4_status_const", bus.av_read_data, 32'h0002_0010);
    pop_n(16, "t4_drain");

    // T5: simultaneous push and pop, half full then full.
    push_n(8, "t5_half");
    cap_valid = 1'b1;
    cap_data = $urandom;
    rd_reg(12'd2, "t5_pushpop");
    cap_valid = 1'b0;
    rd_reg(12'd1, "t5_status");
    push_n(8, "t5_full");
    cap_valid = 1'b1;
    cap_data = $urandom;
    rd_reg(12'd2, "t5_fullpp");
    cap_valid = 1'b0;
    rd_reg(12'd1, "t5_status2");
    chk("t5_status2_const", bus.av_read_data, 32'h0004_000f);

    // T6: clear with concurrent capture, empty read, collision, unmapped.
    cap_valid = 1'b1;
    cap_data = $urandom;
    wr_reg(12'd0, 32'd3, "t6_clr");
    cap_valid = 1'b0;
    rd_reg(12'd2, "t6_empty_pop");
    chk("t6_empty_const", bus.av_read_data, 32'd0);
    rd_reg(12'd0, "t6_ctrl");
    bus.av_read = 1'b1;
    bus.av_write = 1'b1;
    bus.av_addr = 12'd1;
    bus.av_write_data = 32'h0004_0000;
    tick("t6_rw");
    idle();
    rd_reg(12'd3, "t6_addr3");
    rd_reg(12'h402, "t6_nohit");

    // Randomized traffic.
    wr_reg(12'd0, 32'd1, "rnd_en");
    for (int i = 0; i < 600; i++) begin
      int op = int'($urandom_range(0, 9));
      idle();
      cap_valid = ($urandom_range(0, 2) != 0);
      cap_data = $urandom;
      if (op <= 4) begin
        bus.av_read = 1'b1;
        bus.av_addr = ($urandom_range(0, 15) == 0) ? 12'h404 : 12'($urandom_range(0, 3));
        if (op <= 2) bus.av_addr = 12'd2;
      end else if (op == 5) begin
        bus.av_write = 1'b1;
        bus.av_addr = 12'd0;
        bus.av_write_data = {30'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0};
      end else if (op == 6) begin
        bus.av_write = 1'b1;
        bus.av_addr = 12'd1;
        bus.av_write_data = $urandom;
      end else if (op == 7) begin
        bus.av_read = 1'b1;
        bus.av_write = 1'b1;
        bus.av_addr = 12'($urandom_range(0, 3));
        bus.av_write_data = 32'd1;
      end
      tick("rnd");
    end
    idle();

    // T1b: reset mid-stream cancels a pending read result.
    wr_reg(12'd0, 32'd1, "t1b_en");
    push_n(4, "t1b_push");
    bus.av_read = 1'b1;
    bus.av_addr = 12'd2;
    cap_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1b_valid", 32'(bus.av_rd_data_valid), 32'd0);
    chk("t1b_rdata", bus.av_read_data, 32'd0);
    chk("t1b_nempty", 32'(fifo_nempty), 32'd0);
    idle();
    mq.delete();
    cap_en_m = 1'b0;
    ovf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_reg(12'd1, "t1b_status");
    chk("t1b_status_const", bus.av_read_data, 32'h0001_0000);
    rd_reg(12'd0, "t1b_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
